skew_feeder: RTL and testbench



---
 rtl/skew_feeder.sv | 103 ++++++++++
 tb/tb_skew_feeder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/skew_feeder.sv
// Skews one vector of signed operands per beat onto the systolic array row inputs:
// lane i lags lane 0 by i cycles, then flushes and pulses done after the last vector.
module skew_feeder #(
   parameter int unsigned data_size = 8,
   parameter int unsigned rows      = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_last,
   input  logic [rows*data_size-1:0]   in_data,
   output logic [rows*data_size-1:0]   out_a,
   output logic [rows-1:0]             out_valid,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned CntW      = $clog2(rows) + 1;
   localparam bit          SingleRow = (rows == 1);

   typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            accept;

   assign accept = in_valid && in_ready;
   assign done   = done_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      in_ready = (state_q != StFlush);
      busy     = (state_q != StIdle);
      unique case (state_q)
         StIdle, StStream: begin
            if (accept) begin
               if (in_last) begin
                  // With a single lane the last element is already on the output.
                  if (SingleRow) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StFlush;
                     cnt_d   = CntW'(rows - 1);
                  end
               end else begin
                  state_d = StStream;
               end
            end
         end
         StFlush: begin
            if (cnt_q <= CntW'(1)) begin
               state_d = StIdle;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Independent per-lane delay lines; they shift every cycle since the array never stalls.
   for (genvar i = 0; i < rows; i++) begin : g_lane
      logic [i:0][data_size-1:0] dat_q;
      logic [i:0]                vld_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            dat_q <= '0;
            vld_q <= '0;
         end else begin
            dat_q[0] <= accept ? in_data[i*data_size +: data_size] : '0;
            vld_q[0] <= accept;
            for (int j = 1; j <= i; j++) begin
               dat_q[j] <= dat_q[j-1];
               vld_q[j] <= vld_q[j-1];
            end
         end
      end

      assign out_a[i*data_size +: data_size] = dat_q[i];
      assign out_valid[i]                    = vld_q[i];
   end

endmodule

// File: tb/tb_skew_feeder.sv
// Directed self-checking bench for skew_feeder (rows=4 main instance, rows=1 corner instance).
module tb_skew_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_last, in_ready, busy, done;
   logic [31:0] in_data, out_a;
   logic [3:0]  out_valid;

   logic        in_valid1, in_last1, in_ready1, busy1, done1;
   logic [7:0]  in_data1, out_a1;
   logic [0:0]  out_valid1;

   int checks = 0;
   int errors = 0;

   skew_feeder #(.data_size(8), .rows(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_data(in_data), .out_a(out_a), .out_valid(out_valid), .busy(busy), .done(done)
   );

   skew_feeder #(.data_size(8), .rows(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_last(in_last1), .in_data(in_data1), .out_a(out_a1), .out_valid(out_valid1),
      .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] vec(int l0, int l1, int l2, int l3);
      logic [7:0] b0, b1, b2, b3;
      b0 = l0[7:0];
      b1 = l1[7:0];
      b2 = l2[7:0];
      b3 = l3[7:0];
      return {b3, b2, b1, b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks lanes, per-lane valid, ready, busy and done in one call.
   task automatic chk_all(input string tag, input logic [31:0] a, input logic [3:0] v,
                          input logic rdy, input logic bsy, input logic dn);
      chk({tag, ".out_a"}, out_a, a);
      chk({tag, ".out_valid"}, {28'd0, out_valid}, {28'd0, v});
      chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
      chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
   endtask

   initial begin
      // Reset with unknown inputs
      reset     = 1'b0;
      in_valid  = 1'bx;
      in_last   = 1'bx;
      in_data   = 'x;
      in_valid1 = 1'b0;
      in_last1  = 1'b0;
      in_data1  = '0;
      #1;
      chk_all("reset", 32'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      reset    = 1'b1;
      tick();
      chk_all("idle", 32'd0, 4'b0000, 1'b1, 1'b0, 1'b0);

      // Single matrix of three back-to-back beats
      in_valid = 1'b1;
      in_data  = vec(1, 2, 3, 4);
      tick();
      chk_all("m1.e1", vec(1, 0, 0, 0), 4'b0001, 1'b1, 1'b1, 1'b0);
      in_data = vec(5, 6, 7, 8);
      tick();
      chk_all("m1.e2", vec(5, 2, 0, 0), 4'b0011, 1'b1, 1'b1, 1'b0);
      in_data = vec(-1, -2, -3, -4);
      in_last = 1'b1;
      tick();
      chk_all("m1.e3", vec(-1, 6, 3, 0), 4'b0111, 1'b0, 1'b1, 1'b0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      tick();
      chk_all("m1.e4", vec(0, -2, 7, 4), 4'b1110, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("m1.e5", vec(0, 0, -3, 8), 4'b1100, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("m1.e6", vec(0, 0, 0, -4), 4'b1000, 1'b1, 1'b0, 1'b1);
      tick();
      chk_all("m1.e7", 32'd0, 4'b0000, 1'b1, 1'b0, 1'b0);

      // Bubble between two beats; in_last on the bubble must be ignored
      in_valid = 1'b1;
      in_data  = vec(10, 20, 30, 40);
      tick();
      chk_all("bub.e1", vec(10, 0, 0, 0), 4'b0001, 1'b1, 1'b1, 1'b0);
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = vec(99, 99, 99, 99);
      tick();
      chk_all("bub.e2", vec(0, 20, 0, 0), 4'b0010, 1'b1, 1'b1, 1'b0);
      in_valid = 1'b1;
      in_data  = vec(11, 21, 31, 41);
      tick();
      chk_all("bub.e3", vec(11, 0, 30, 0), 4'b0101, 1'b0, 1'b1, 1'b0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      tick();
      chk_all("bub.e4", vec(0, 21, 0, 40), 4'b1010, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("bub.e5", vec(0, 0, 31, 0), 4'b0100, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("bub.e6", vec(0, 0, 0, 41), 4'b1000, 1'b1, 1'b0, 1'b1);
      tick();
      chk_all("bub.e7", 32'd0, 4'b0000, 1'b1, 1'b0, 1'b0);

      // Flush backpressure with extreme values; in_valid held high through FLUSH
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = vec(-128, 127, -128, 127);
      tick();
      chk_all("bp.e1", vec(-128, 0, 0, 0), 4'b0001, 1'b0, 1'b1, 1'b0);
      in_data = vec(127, -128, 127, -128);
      tick();
      chk_all("bp.e2", vec(0, 127, 0, 0), 4'b0010, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("bp.e3", vec(0, 0, -128, 0), 4'b0100, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("bp.e4", vec(0, 0, 0, 127), 4'b1000, 1'b1, 1'b0, 1'b1);
      tick();
      chk_all("bp.e5", vec(127, 0, 0, 0), 4'b0001, 1'b0, 1'b1, 1'b0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      tick();
      chk_all("bp.e6", vec(0, -128, 0, 0), 4'b0010, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("bp.e7", vec(0, 0, 127, 0), 4'b0100, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("bp.e8", vec(0, 0, 0, -128), 4'b1000, 1'b1, 1'b0, 1'b1);
      tick();
      chk_all("bp.e9", 32'd0, 4'b0000, 1'b1, 1'b0, 1'b0);

      // Reset one cycle into FLUSH
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = vec(5, 6, 7, 8);
      tick();
      chk_all("rst.e1", vec(5, 0, 0, 0), 4'b0001, 1'b0, 1'b1, 1'b0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      tick();
      chk_all("rst.e2", vec(0, 6, 0, 0), 4'b0010, 1'b0, 1'b1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk_all("rst.async", 32'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("rst.held", 32'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      for (int n = 0; n < 4; n++) begin
         tick();
         chk_all("rst.nodone", 32'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
      end
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = vec(9, -9, 1, -1);
      tick();
      chk_all("rst.s1", vec(9, 0, 0, 0), 4'b0001, 1'b0, 1'b1, 1'b0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      tick();
      tick();
      chk_all("rst.s3", vec(0, 0, 1, 0), 4'b0100, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("rst.s4", vec(0, 0, 0, -1), 4'b1000, 1'b1, 1'b0, 1'b1);
      tick();
      chk_all("rst.s5", 32'd0, 4'b0000, 1'b1, 1'b0, 1'b0);

      // rows=1: ready never drops, done back-to-back
      in_valid1 = 1'b1;
      in_last1  = 1'b1;
      in_data1  = 8'h7f;
      #1;
      chk("r1.ready0", {31'd0, in_ready1}, 32'd1);
      tick();
      chk("r1.a1", {24'd0, out_a1}, 32'h7f);
      chk("r1.done1", {31'd0, done1}, 32'd1);
      chk("r1.ready1", {31'd0, in_ready1}, 32'd1);
      chk("r1.busy1", {31'd0, busy1}, 32'd0);
      in_data1 = 8'h80;
      tick();
      chk("r1.a2", {24'd0, out_a1}, 32'h80);
      chk("r1.done2", {31'd0, done1}, 32'd1);
      chk("r1.valid2", {31'd0, out_valid1}, 32'd1);
      in_valid1 = 1'b0;
      in_last1  = 1'b0;
      in_data1  = '0;
      tick();
      chk("r1.a3", {24'd0, out_a1}, 32'd0);
      chk("r1.done3", {31'd0, done1}, 32'd0);
      chk("r1.valid3", {31'd0, out_valid1}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
